// File: rtl/raid_pkg.sv
// raid_pkg: shared widths, drive codes, stripe record and writer FSM encodings
package raid_pkg;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {DRIVE_D0 = 2'd0, DRIVE_D1 = 2'd1, DRIVE_P = 2'd2} drive_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] p;
  } stripe_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_D0 = 2'd1;
  localparam logic [1:0] ST_WR_D1 = 2'd2;
  localparam logic [1:0] ST_WR_P  = 2'd3;
endpackage

// File: rtl/stripe_fifo.sv
// stripe_fifo: synchronous stripe FIFO; ports clk/reset, push/pop strobes, wdata in, registered head, full/empty/count
module stripe_fifo import raid_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  stripe_t                  wdata,
  output stripe_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  stripe_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/raid_stripe_writer.sv
// raid_stripe_writer: buffers parity-stage stripes, serialises each into D0/D1/P writes; ports clk/reset, in_* stripe, ssd_* write bus, busy/overflow/stripes_written status
module raid_stripe_writer #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_d0,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_p,
  output logic              ssd_wr_en,
  output logic [1:0]        ssd_drive_sel,
  output logic [ADDR_W-1:0] ssd_addr,
  output logic [DATA_W-1:0] ssd_wdata,
  input  logic              ssd_wr_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       stripes_written
);
  import raid_pkg::*;
  logic [1:0] state, state_nx;
  stripe_t head;
  logic full, empty, push, pop, hs;
  logic [$clog2(FIFO_DEPTH):0] count;
  stripe_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata('{addr: in_addr, d0: in_d0, d1: in_d1, p: in_p}),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign ssd_wr_en     = state != ST_IDLE;
  assign hs            = ssd_wr_en && ssd_wr_ready;
  assign pop           = state == ST_WR_P && hs;
  // a full FIFO still accepts when the head is retired in the same cycle
  assign push          = in_valid && (!full || pop);
  assign busy          = !empty || ssd_wr_en;
  assign ssd_drive_sel = state == ST_WR_D1 ? DRIVE_D1 : state == ST_WR_P ? DRIVE_P : DRIVE_D0;
  assign ssd_addr      = ssd_wr_en ? head.addr : '0;
  assign ssd_wdata     = state == ST_WR_D0 ? head.d0 : state == ST_WR_D1 ? head.d1 :
                         state == ST_WR_P ? head.p : '0;
  // after the parity write, go straight to the next stripe if one survives the pop
  assign state_nx = state == ST_IDLE ? (empty ? ST_IDLE : ST_WR_D0) :
                    !hs ? state :
                    state == ST_WR_D0 ? ST_WR_D1 :
                    state == ST_WR_D1 ? ST_WR_P :
                    (count > 1 || push) ? ST_WR_D0 : ST_IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state           <= ST_IDLE;
      overflow        <= 1'b0;
      stripes_written <= '0;
    end else begin
      state           <= state_nx;
      overflow        <= overflow || (in_valid && !push);
      stripes_written <= stripes_written + {15'd0, pop};
    end
endmodule

// File: tb/tb_raid_stripe_writer.sv
// tb_raid_stripe_writer: scoreboard bench for raid_stripe_writer
module tb_raid_stripe_writer;
  typedef struct packed {logic [1:0] sel; logic [7:0] addr; logic [11:0] data;} wr_t;
  logic clk = 0, reset = 1, in_valid = 0, ssd_wr_ready = 1;
  logic [7:0] in_addr = 0;
  logic [11:0] in_d0 = 0, in_d1 = 0, in_p = 0;
  logic ssd_wr_en, busy, overflow;
  logic [1:0] ssd_drive_sel;
  logic [7:0] ssd_addr;
  logic [11:0] ssd_wdata;
  logic [15:0] stripes_written;
  int checks = 0, failures = 0, cyc = 0, first_hs = -1, last_hs = -1;
  wr_t q[$];

  raid_stripe_writer #(.DATA_W(12), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
    .in_d0(in_d0), .in_d1(in_d1), .in_p(in_p), .ssd_wr_en(ssd_wr_en),
    .ssd_drive_sel(ssd_drive_sel), .ssd_addr(ssd_addr), .ssd_wdata(ssd_wdata),
    .ssd_wr_ready(ssd_wr_ready), .busy(busy), .overflow(overflow),
    .stripes_written(stripes_written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset && ssd_wr_en) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got sel=%0d addr=%h data=%h, no write expected", ssd_drive_sel, ssd_addr, ssd_wdata);
      end else begin
        if ({ssd_drive_sel, ssd_addr, ssd_wdata} !== q[0]) begin
          failures++;
          $display("FAIL write got sel=%0d addr=%h data=%h expected sel=%0d addr=%h data=%h",
                   ssd_drive_sel, ssd_addr, ssd_wdata, q[0].sel, q[0].addr, q[0].data);
        end
        if (ssd_wr_ready) begin
          void'(q.pop_front());
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] a, input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] p, input bit keep);
    in_valid = 1; in_addr = a; in_d0 = d0; in_d1 = d1; in_p = p;
    if (keep) begin
      q.push_back({2'd0, a, d0});
      q.push_back({2'd1, a, d1});
      q.push_back({2'd2, a, p});
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] p, input bit keep);
    @(posedge clk); #1;
    set_in(a, d0, d1, p, keep);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy) break;
    end
    chk({name, "_drained"}, {31'd0, q.size() == 0 && !busy}, 32'd1);
  endtask

  task automatic wait_sel(input logic [1:0] s, input string name);
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      hit = ssd_wr_en && ssd_drive_sel == s;
    end
    chk({name, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_wr_en"}, {31'd0, ssd_wr_en}, 32'd0);
    chk({name, "_sel"}, {30'd0, ssd_drive_sel}, 32'd0);
    chk({name, "_addr"}, {24'd0, ssd_addr}, 32'd0);
    chk({name, "_wdata"}, {20'd0, ssd_wdata}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({name, "_written"}, {16'd0, stripes_written}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    q.delete();
    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    #1 check_reset_outputs("por");
    #20;
    @(posedge clk); #1;
    reset = 0;

    send(8'h15, 12'hABC, 12'h123, 12'hB9F, 1);
    @(negedge clk) chk("lat_n", {31'd0, ssd_wr_en}, 32'd0);
    idle();
    @(negedge clk) chk("lat_n1", {31'd0, ssd_wr_en}, 32'd0);
    @(negedge clk) chk("lat_n2", {29'd0, ssd_wr_en, ssd_drive_sel}, 32'h4);
    wait_drain("single");
    chk("single_written", {16'd0, stripes_written}, 32'd1);

    send(8'h15, 12'hABC, 12'h123, 12'hB9F, 1);
    idle();
    wait_sel(2'd1, "stall");
    ssd_wr_ready = 0;
    repeat (3) @(posedge clk);
    #1 ssd_wr_ready = 1;
    wait_drain("stall");
    chk("stall_written", {16'd0, stripes_written}, 32'd2);

    first_hs = -1;
    for (int i = 0; i < 4; i++)
      send(8'h20 + 8'(i), 12'h100 + 12'(i), 12'h200 + 12'(i), 12'h300 + 12'(i), 1);
    idle();
    wait_drain("burst4");
    chk("burst4_span", last_hs - first_hs, 32'd11);
    chk("burst4_overflow", {31'd0, overflow}, 32'd0);
    chk("burst4_written", {16'd0, stripes_written}, 32'd6);

    ssd_wr_ready = 0;
    for (int i = 0; i < 6; i++)
      send(8'h40 + 8'(i), 12'h410 + 12'(i), 12'h420 + 12'(i), 12'h430 + 12'(i), i < 4);
    idle();
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    ssd_wr_ready = 1;
    wait_drain("ovf");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_written", {16'd0, stripes_written}, 32'd10);

    do_reset();
    ssd_wr_ready = 0;
    for (int i = 0; i < 4; i++)
      send(8'h60 + 8'(i), 12'h610 + 12'(i), 12'h620 + 12'(i), 12'h630 + 12'(i), 1);
    idle();
    ssd_wr_ready = 1;
    wait_sel(2'd2, "popfull");
    set_in(8'h77, 12'h777, 12'h788, 12'h799, 1);
    idle();
    chk("popfull_overflow", {31'd0, overflow}, 32'd0);
    wait_drain("popfull");
    chk("popfull_written", {16'd0, stripes_written}, 32'd5);
    chk("popfull_overflow_end", {31'd0, overflow}, 32'd0);

    send(8'h99, 12'h9A0, 12'h9B0, 12'h9C0, 1);
    idle();
    wait_sel(2'd1, "rst_mid");
    reset = 1;
    q.delete();
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    reset = 0;
    repeat (6) @(negedge clk) chk("rst_quiet", {31'd0, ssd_wr_en}, 32'd0);
    chk("rst_quiet_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raid_stripe_writer.md
# raid_stripe_writer

Downstream consumer of the RAID parity stage. Accepts one stripe per cycle (two Hamming-encoded data words, their XOR parity, and a stripe address), buffers stripes in a small FIFO, and serialises each stripe into three writes on a shared single-port SSD write bus: drive 0 (D0), drive 1 (D1), drive 2 (P). The parity stage has no backpressure, so this block absorbs bursts and flags loss on overflow.

## Interface
- DATA_W, 12, width of encoded data and parity words
- ADDR_W, 8, stripe address width
- FIFO_DEPTH, 4, stripe buffer entries (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  stripe present this cycle; in_* ignored when low
- in_addr  in  ADDR_W  stripe address
- in_d0  in  DATA_W  encoded word for drive 0
- in_d1  in  DATA_W  encoded word for drive 1
- in_p  in  DATA_W  parity word for drive 2
- ssd_wr_en  out  1  write request valid
- ssd_drive_sel  out  2  target drive: 0=D0, 1=D1, 2=P; 3 never driven
- ssd_addr  out  ADDR_W  write address (same for all three writes of a stripe)
- ssd_wdata  out  DATA_W  write data
- ssd_wr_ready  in  1  SSD accepts the write when high with ssd_wr_en
- busy  out  1  FIFO not empty or FSM not IDLE
- overflow  out  1  sticky: a stripe was dropped
- stripes_written  out  16  count of fully written stripes

## Operation
- FIFO: push when in_valid and (not full, or pop in the same cycle). in_valid while full without pop: stripe dropped, overflow set, held until reset.
- FSM states: IDLE, WR_D0, WR_D1, WR_P.
  - IDLE: FIFO non-empty → WR_D0; else stay.
  - WR_D0/WR_D1/WR_P: ssd_wr_en=1, ssd_drive_sel=0/1/2, ssd_addr=head.addr, ssd_wdata=head.d0/d1/p. Hold all outputs stable until ssd_wr_ready; on handshake advance WR_D0→WR_D1→WR_P.
  - WR_P handshake: pop FIFO head, stripes_written+1 (wraps 16'hFFFF→0); next state WR_D0 if another entry remains after pop, else IDLE.
- In IDLE: ssd_wr_en=0, ssd_drive_sel=0, ssd_addr=0, ssd_wdata=0.
- Stripes written in arrival order; writes of a stripe never interleave with another stripe.
- ssd_wr_ready while ssd_wr_en low: ignored.

## Timing
- Reset values: ssd_wr_en=0, ssd_drive_sel=0, ssd_addr=0, ssd_wdata=0, busy=0, overflow=0, stripes_written=0; FIFO empty; state IDLE.
- Reset mid-operation: in-flight and buffered stripes discarded; no partial stripe resumes.
- ssd_* outputs decoded from registered state and registered FIFO head (no combinational path from in_* to ssd_*).
- Latency: in_valid at cycle N into empty FIFO/IDLE → ssd_wr_en high with drive 0 at N+2.
- Back-to-back throughput with ssd_wr_ready tied high: one stripe per 3 cycles, no bubble between stripes.
- Sustained in_valid every cycle exceeds drain rate; overflow expected after FIFO_DEPTH + in-flight slack.
- busy deasserts the cycle after the final WR_P handshake leaves the FIFO empty.

## Structure
- Shared raid_pkg: DATA_W, ADDR_W defaults; drive enum (DRIVE_D0=0, DRIVE_D1=1, DRIVE_P=2); stripe struct {addr, d0, d1, p}; writer state enum.
- Sub-module stripe_fifo: synchronous FIFO of stripe structs, FIFO_DEPTH entries, push/pop/full/empty/count, push-while-full-with-pop allowed. FSM, counter, overflow in the top.

## Test plan
- Single stripe addr=0x15, d0=0xABC, d1=0x123, p=0xB9F, ready high → writes (0,0x15,0xABC),(1,0x15,0x123),(2,0x15,0xB9F) on cycles N+2..N+4; stripes_written=1; busy low after.
- Same stripe, ssd_wr_ready low 3 cycles during WR_D1 → ssd_drive_sel=1, ssd_wdata=0x123 stable all 3 cycles; no skipped or duplicated write.
- Four consecutive stripes, ready high → 12 writes in order, no idle cycle between stripes, overflow=0, stripes_written=4.
- Ready low, 6 consecutive stripes (FIFO_DEPTH=4) → first 4 retained, overflow=1 sticky; releasing ready yields exactly 4 stripes in order.
- Full FIFO with WR_P handshake and in_valid in the same cycle → new stripe accepted, overflow stays 0.
- Reset asserted during WR_D1 → all outputs to reset values immediately; after release with no input, ssd_wr_en stays 0.
